// File: rtl/wb_axis_in_pkg.sv
// Shared definitions for the Wishbone-to-AXI-Stream input bridge: register
// offsets, STATUS bit positions, bridge FSM states and byte-lane merge helper.
package wb_axis_in_pkg;

   localparam logic [7:0] OFS_LEN     = 8'h10;
   localparam logic [7:0] OFS_PUSH    = 8'h80;
   localparam logic [7:0] OFS_PUSH_NB = 8'h84;
   localparam logic [7:0] OFS_STATUS  = 8'h88;

   localparam int ST_FULL_BIT  = 0;
   localparam int ST_EMPTY_BIT = 1;
   localparam int ST_OVF_BIT   = 2;
   localparam int ST_PKT_BIT   = 3;
   localparam int ST_OCC_LSB   = 8;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_ACK       = 2'd1,
      S_WAIT_PUSH = 2'd2
   } wb_state_e;

   // Merge the byte lanes selected by sel from new_v into old_v.
   function automatic logic [31:0] apply_sel(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
      logic [31:0] r;
      r = old_v;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) begin
            r[8*b +: 8] = new_v[8*b +: 8];
         end else begin
            r[8*b +: 8] = old_v[8*b +: 8];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/axis_in_fifo.sv
// Pointer-based circular FIFO; push at full is honoured only together with a pop.
// Head data reads as zero while empty so the stream data is clean after reset.
module axis_in_fifo #(
   parameter int pWIDTH = 32,
   parameter int pDEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [pWIDTH-1:0]        din_i,
   output logic [pWIDTH-1:0]        dout_o,
   output logic [$clog2(pDEPTH):0]  count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int AW = $clog2(pDEPTH);
   localparam int CW = AW + 1;

   logic [pWIDTH-1:0] mem_q [pDEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              push_s, pop_s;

   assign empty_o = (count_q == {CW{1'b0}});
   assign full_o  = (count_q == CW'(pDEPTH));
   assign pop_s   = pop_i & ~empty_o;
   assign push_s  = push_i & (~full_o | pop_s);
   assign count_o = count_q;
   assign dout_o  = empty_o ? {pWIDTH{1'b0}} : mem_q[rd_ptr_q];

   // Pointer advance (power-of-two depth wraps naturally) and occupancy update.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {CW{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk_i) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

endmodule

// File: rtl/wb_axis_in_fifo.sv
// Wishbone slave feeding an AXI-Stream master through a FIFO, with packet tlast
// generation and sticky status. Define WB_AXISIN_NB_PUSH_EN to enable PUSH_NB.
module wb_axis_in_fifo
   import wb_axis_in_pkg::*;
#(
   parameter int          pDATA_WIDTH = 32,
   parameter int          pFIFO_DEPTH = 4,
   parameter logic [7:0]  pBASE_HI    = 8'h30
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_n_i,
   input  logic                   wbs_stb_i,
   input  logic                   wbs_cyc_i,
   input  logic                   wbs_we_i,
   input  logic [3:0]             wbs_sel_i,
   input  logic [31:0]            wbs_adr_i,
   input  logic [31:0]            wbs_dat_i,
   output logic                   wbs_ack_o,
   output logic [31:0]            wbs_dat_o,
   output logic                   ss_tvalid,
   output logic [pDATA_WIDTH-1:0] ss_tdata,
   output logic                   ss_tlast,
   input  logic                   ss_tready
);

   localparam int pCNT_WIDTH = $clog2(pFIFO_DEPTH) + 1;

   wb_state_e               state_q, state_d;
   logic                    ack_q, ack_d;
   logic [31:0]             dat_q, dat_d;
   logic [31:0]             len_q, len_d;
   logic [31:0]             beat_q, beat_d;
   logic                    pkt_q, pkt_d;
   logic                    ovf_s;

   logic [pCNT_WIDTH-1:0]   count_s;
   logic                    full_s, empty_s;
   logic                    pop_s, push_ok_s, push_s;
   logic                    req_s, bus_s;
   logic [7:0]              offset_s;
   logic                    len_we_s, stat_rd_s;
   logic [31:0]             rdata_s, status_s;
   logic                    unused_s;

   assign unused_s  = ^{wbs_adr_i[23:8]};
   assign bus_s     = wbs_stb_i & wbs_cyc_i;
   assign req_s     = bus_s & (wbs_adr_i[31:24] == pBASE_HI) & ~ack_q;
   assign offset_s  = wbs_adr_i[7:0];
   assign ss_tvalid = ~empty_s;
   assign pop_s     = ss_tvalid & ss_tready;
   assign push_ok_s = ~full_s | pop_s;
   assign ss_tlast  = ss_tvalid & (len_q != 32'd0) & (beat_q == (len_q - 32'd1));
   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;

   axis_in_fifo #(
      .pWIDTH (pDATA_WIDTH),
      .pDEPTH (pFIFO_DEPTH)
   ) u_fifo (
      .clk_i   (wb_clk_i),
      .rst_n_i (wb_rst_n_i),
      .push_i  (push_s),
      .pop_i   (pop_s),
      .din_i   (wbs_dat_i),
      .dout_o  (ss_tdata),
      .count_o (count_s),
      .full_o  (full_s),
      .empty_o (empty_s)
   );

   // STATUS word assembled from live FIFO state and sticky flags.
   always_comb begin
      status_s                 = 32'h0000_0000;
      status_s[ST_FULL_BIT]    = full_s;
      status_s[ST_EMPTY_BIT]   = empty_s;
      status_s[ST_OVF_BIT]     = ovf_s;
      status_s[ST_PKT_BIT]     = pkt_q;
      status_s[ST_OCC_LSB +: 8] = 8'(count_s);
   end

`ifdef WB_AXISIN_NB_PUSH_EN
   logic ovf_q, ovf_d, ovf_set_s;
   assign ovf_s = ovf_q;
`else
   assign ovf_s = 1'b0;
`endif

   // Bridge FSM: decode, register actions, push stall and one-cycle ack.
   always_comb begin
      state_d   = state_q;
      push_s    = 1'b0;
      len_we_s  = 1'b0;
      stat_rd_s = 1'b0;
      rdata_s   = 32'h0000_0000;
`ifdef WB_AXISIN_NB_PUSH_EN
      ovf_set_s = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (req_s && wbs_we_i && (offset_s == OFS_PUSH)) begin
               if (push_ok_s) begin
                  push_s  = 1'b1;
                  state_d = S_ACK;
               end else begin
                  state_d = S_WAIT_PUSH;
               end
            end else if (req_s) begin
               state_d = S_ACK;
               if (wbs_we_i) begin
                  if (offset_s == OFS_LEN) begin
                     len_we_s = 1'b1;
                  end
`ifdef WB_AXISIN_NB_PUSH_EN
                  else if (offset_s == OFS_PUSH_NB) begin
                     if (push_ok_s) begin
                        push_s = 1'b1;
                     end else begin
                        ovf_set_s = 1'b1;
                     end
                  end
`endif
                  else begin
                     len_we_s = 1'b0;
                  end
               end else if (offset_s == OFS_LEN) begin
                  rdata_s = len_q;
               end else if (offset_s == OFS_STATUS) begin
                  rdata_s   = status_s;
                  stat_rd_s = 1'b1;
               end else begin
                  rdata_s = 32'h0000_0000;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT_PUSH: begin
            if (!bus_s) begin
               state_d = S_IDLE;
            end else if (push_ok_s) begin
               push_s  = 1'b1;
               state_d = S_ACK;
            end else begin
               state_d = S_WAIT_PUSH;
            end
         end
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Next values for ack/read data, LEN, beat counter and packet-done flag.
   always_comb begin
      ack_d  = (state_d == S_ACK);
      dat_d  = (state_d == S_ACK) ? rdata_s : 32'h0000_0000;
      len_d  = len_we_s ? apply_sel(len_q, wbs_dat_i, wbs_sel_i) : len_q;
      beat_d = beat_q;
      if (len_we_s) begin
         beat_d = 32'd0;
      end else if (pop_s) begin
         beat_d = ss_tlast ? 32'd0 : (beat_q + 32'd1);
      end else begin
         beat_d = beat_q;
      end
      pkt_d = (pop_s & ss_tlast) | (pkt_q & ~stat_rd_s);
   end

   // Control and register state.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state_q <= S_IDLE;
         ack_q   <= 1'b0;
         dat_q   <= 32'h0000_0000;
         len_q   <= 32'h0000_0000;
         beat_q  <= 32'h0000_0000;
         pkt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         dat_q   <= dat_d;
         len_q   <= len_d;
         beat_q  <= beat_d;
         pkt_q   <= pkt_d;
      end
   end

`ifdef WB_AXISIN_NB_PUSH_EN
   // Sticky overflow from dropped non-blocking pushes; a set beats a read-clear.
   always_comb begin
      ovf_d = ovf_set_s | (ovf_q & ~stat_rd_s);
   end

   // Overflow flag register.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end
`endif

endmodule

// File: tb/tb_wb_axis_in_fifo.sv
// Self-checking bench: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_wb_axis_in_fifo;

   localparam int DEPTH = 4;
`ifdef WB_AXISIN_NB_PUSH_EN
   localparam bit NB = 1'b1;
`else
   localparam bit NB = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
   logic [3:0]  sel = 4'h0;
   logic [31:0] adr = 32'h0, dat_i = 32'h0;
   logic        ack;
   logic [31:0] dat_o;
   logic        tvalid, tlast;
   logic [31:0] tdata;
   logic        tready = 1'b0;

   int checks = 0;
   int failures = 0;

   bit   ready_rand = 1'b0;
   logic force_ready = 1'b0;

   logic [31:0] mq[$];
   logic [31:0] m_len = 32'h0, m_beat = 32'h0, m_dat = 32'h0;
   bit          m_ovf = 1'b0, m_pkt = 1'b0, m_ack = 1'b0, m_wait = 1'b0;
   logic [31:0] popped[$];
   logic [31:0] tlast_seen[$];

   always #5 clk = ~clk;

   wb_axis_in_fifo #(.pFIFO_DEPTH(DEPTH)) dut (
      .wb_clk_i   (clk),
      .wb_rst_n_i (rst_n),
      .wbs_stb_i  (stb),
      .wbs_cyc_i  (cyc),
      .wbs_we_i   (we),
      .wbs_sel_i  (sel),
      .wbs_adr_i  (adr),
      .wbs_dat_i  (dat_i),
      .wbs_ack_o  (ack),
      .wbs_dat_o  (dat_o),
      .ss_tvalid  (tvalid),
      .ss_tdata   (tdata),
      .ss_tlast   (tlast),
      .ss_tready  (tready)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Downstream ready, applied after the bus drivers have settled.
   always @(posedge clk) begin
      #2;
      tready = ready_rand ? 1'($urandom_range(0, 1)) : force_ready;
   end

   // Reference model: compare current outputs, then advance across the coming edge.
   always @(negedge clk) begin
      bit          exp_valid, exp_last, pop, can_push, req;
      bit          do_push, len_wr, st_rd, set_ovf, n_ack;
      logic [31:0] exp_data, n_dat, stat;
      logic [7:0]  off;
      int          occ;
      if (!rst_n) begin
         mq.delete();
         m_len = 32'h0; m_beat = 32'h0; m_dat = 32'h0;
         m_ovf = 1'b0; m_pkt = 1'b0; m_ack = 1'b0; m_wait = 1'b0;
      end
      exp_valid = (mq.size() != 0);
      exp_data  = exp_valid ? mq[0] : 32'h0;
      exp_last  = exp_valid && (m_len != 32'h0) && (m_beat == m_len - 32'h1);
      chk("tvalid", {31'h0, tvalid}, {31'h0, exp_valid});
      chk("tdata", tdata, exp_data);
      chk("tlast", {31'h0, tlast}, {31'h0, exp_last});
      chk("ack", {31'h0, ack}, {31'h0, m_ack});
      chk("dat_o", dat_o, m_dat);
      if (rst_n) begin
         occ      = mq.size();
         pop      = exp_valid && (tready === 1'b1);
         can_push = (occ < DEPTH) || pop;
         req      = stb && cyc && (adr[31:24] == 8'h30) && !m_ack;
         off      = adr[7:0];
         stat     = 32'h0;
         stat[15:8] = 8'(occ);
         stat[3]  = m_pkt;
         stat[2]  = NB && m_ovf;
         stat[1]  = (occ == 0);
         stat[0]  = (occ == DEPTH);
         do_push = 0; len_wr = 0; st_rd = 0; set_ovf = 0; n_ack = 0; n_dat = 32'h0;
         if (m_wait) begin
            if (!(stb && cyc)) m_wait = 0;
            else if (can_push) begin do_push = 1; n_ack = 1; m_wait = 0; end
         end else if (req) begin
            if (we && off == 8'h80) begin
               if (can_push) begin do_push = 1; n_ack = 1; end
               else m_wait = 1;
            end else begin
               n_ack = 1;
               if (we) begin
                  if (off == 8'h10) len_wr = 1;
                  else if (NB && off == 8'h84) begin
                     if (can_push) do_push = 1; else set_ovf = 1;
                  end
               end else if (off == 8'h10) n_dat = m_len;
               else if (off == 8'h88) begin n_dat = stat; st_rd = 1; end
            end
         end
         if (pop) begin
            popped.push_back(mq[0]);
            if (exp_last) tlast_seen.push_back(mq[0]);
            void'(mq.pop_front());
            m_beat = exp_last ? 32'h0 : m_beat + 32'h1;
         end
         if (do_push) mq.push_back(dat_i);
         if (len_wr) begin
            for (int b = 0; b < 4; b++) if (sel[b]) m_len[8*b +: 8] = dat_i[8*b +: 8];
            m_beat = 32'h0;
         end
         m_pkt = (pop && exp_last) || (m_pkt && !st_rd);
         m_ovf = set_ovf || (m_ovf && !st_rd);
         m_ack = n_ack;
         m_dat = n_dat;
      end
   end

   task automatic wb_cycle(input logic w, input logic [7:0] hi, input logic [7:0] off,
                           input logic [31:0] d, input logic [3:0] s, output logic [31:0] rd);
      bit got;
      stb = 1'b1; cyc = 1'b1; we = w; adr = {hi, 16'h0, off}; dat_i = d; sel = s;
      got = 0; rd = 32'h0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (ack) begin rd = dat_o; got = 1; break; end
      end
      chk("ack_timeout", {31'h0, got}, 32'h1);
      @(posedge clk); #1;
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
   endtask

   task automatic wb_wr(input logic [7:0] off, input logic [31:0] d);
      logic [31:0] rd;
      wb_cycle(1'b1, 8'h30, off, d, 4'hF, rd);
   endtask

   task automatic wb_rd(input logic [7:0] off, output logic [31:0] rd);
      wb_cycle(1'b0, 8'h30, off, 32'h0, 4'hF, rd);
   endtask

   task automatic wait_empty();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!tvalid) break;
      end
      chk("drain", {31'h0, tvalid}, 32'h0);
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] rd;
      bit          found;
      // Reset and idle status.
      idle(3);
      @(negedge clk);
      chk("rst_tvalid", {31'h0, tvalid}, 32'h0);
      chk("rst_ack", {31'h0, ack}, 32'h0);
      @(posedge clk); #1; rst_n = 1'b1;
      idle(1);
      wb_rd(8'h88, rd); chk("status_reset", rd, 32'h0000_0002);

      // Fill to full with the stream stalled, then a stalled fifth push.
      force_ready = 1'b0;
      for (int i = 1; i <= 4; i++) wb_wr(8'h80, 32'(i));
      wb_rd(8'h88, rd); chk("status_full", rd, 32'h0000_0401);
      stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = 32'h3000_0080; dat_i = 32'h5; sel = 4'hF;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); chk("stall_noack", {31'h0, ack}, 32'h0);
      end
      @(posedge clk); #1; force_ready = 1'b1;
      popped.delete();
      @(negedge clk); chk("head_before_pop", tdata, 32'h1);
      @(posedge clk); #1; force_ready = 1'b0;
      @(negedge clk); chk("stall_ack", {31'h0, ack}, 32'h1);
      @(posedge clk); #1; stb = 1'b0; cyc = 1'b0; we = 1'b0;
      wb_rd(8'h88, rd); chk("status_still_full", rd, 32'h0000_0401);
      chk("popped_count", 32'(popped.size()), 32'h1);
      force_ready = 1'b1;
      wait_empty();

      // LEN=3 packetisation.
      wb_wr(8'h10, 32'h3);
      tlast_seen.delete();
      for (int i = 10; i <= 13; i++) wb_wr(8'h80, 32'(i));
      idle(4);
      chk("tlast_count", 32'(tlast_seen.size()), 32'h1);
      if (tlast_seen.size() > 0) chk("tlast_data", tlast_seen[0], 32'd12);
      wb_rd(8'h88, rd); chk("status_pkt_done", rd, 32'h0000_000A);
      wb_rd(8'h88, rd); chk("status_pkt_cleared", rd, 32'h0000_0002);

      // Byte-lane LEN write, then LEN=0 never asserts tlast.
      wb_cycle(1'b1, 8'h30, 8'h10, 32'h1234_5678, 4'b0101, rd);
      wb_rd(8'h10, rd); chk("len_bytelane", rd, 32'h0034_0078);
      wb_wr(8'h10, 32'h0);
      tlast_seen.delete();
      for (int i = 0; i < 5; i++) wb_wr(8'h80, 32'h100 + 32'(i));
      idle(4);
      chk("len0_no_tlast", 32'(tlast_seen.size()), 32'h0);

      // Non-blocking push at full.
      force_ready = 1'b0;
      for (int i = 0; i < 4; i++) wb_wr(8'h80, 32'h20 + 32'(i));
      popped.delete();
      wb_wr(8'h84, 32'h0000_DEAD);
      wb_rd(8'h88, rd); chk("status_nb", rd, NB ? 32'h0000_0405 : 32'h0000_0401);
      wb_rd(8'h88, rd); chk("status_nb_clr", rd, 32'h0000_0401);
      force_ready = 1'b1;
      wait_empty();
      found = 0;
      foreach (popped[i]) if (popped[i] == 32'h0000_DEAD) found = 1;
      chk("nb_dropped", {31'h0, found}, 32'h0);

      // Unmapped offset and out-of-range address.
      wb_rd(8'h40, rd); chk("unmapped_read", rd, 32'h0);
      stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h3100_0088;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); chk("out_of_range_noack", {31'h0, ack}, 32'h0);
      end
      @(posedge clk); #1; stb = 1'b0; cyc = 1'b0;

      // Reset mid-transfer with a stalled push.
      force_ready = 1'b0;
      for (int i = 0; i < 4; i++) wb_wr(8'h80, 32'h40 + 32'(i));
      stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = 32'h3000_0080; dat_i = 32'h99; sel = 4'hF;
      idle(3);
      rst_n = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0;
      @(negedge clk);
      chk("rst_mid_tvalid", {31'h0, tvalid}, 32'h0);
      chk("rst_mid_ack", {31'h0, ack}, 32'h0);
      @(posedge clk); #1; rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); chk("post_rst_noack", {31'h0, ack}, 32'h0);
      end
      @(posedge clk); #1;
      wb_rd(8'h88, rd); chk("status_post_rst", rd, 32'h0000_0002);

      // Randomized traffic against the model.
      ready_rand = 1'b1;
      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 7))
            0, 1: wb_wr(8'h80, $urandom);
            2:    wb_wr(8'h84, $urandom);
            3:    wb_rd(8'h88, rd);
            4:    wb_cycle(1'b1, 8'h30, 8'h10, 32'($urandom_range(0, 5)), 4'($urandom_range(0, 15)), rd);
            5:    wb_rd(8'h10, rd);
            6: begin
               stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = 32'h3000_0080; dat_i = $urandom; sel = 4'hF;
               idle($urandom_range(1, 3));
               stb = 1'b0; cyc = 1'b0; we = 1'b0;
               idle(1);
            end
            default: idle($urandom_range(1, 4));
         endcase
      end
      ready_rand = 1'b0;
      force_ready = 1'b1;
      idle(2);
      wait_empty();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
